debug_reg_dump: RTL and testbench

// - Reader side of the register file's debug read port (address out, word in).
// - On a start request, sweeps registers 0..CELDAS-1 and reads each one through that port.
// - Splits each word into bytes and hands them one at a time to the UART transmitter via a start/done handshake.
// - Sits in the debug unit, between the register file and the UART TX.

---
 rtl/debug_pkg.sv | 11 +
 rtl/debug_byte_sel.sv | 16 +
 rtl/debug_reg_dump.sv | 89 ++++++++
 tb/tb_debug_reg_dump.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared state encoding and byte-geometry helpers for the debug unit.
package debug_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;
    localparam int DEF_NBITS      = 32;
    localparam int DEF_BYTE       = 8;
    localparam int BYTES_PER_WORD = DEF_NBITS / DEF_BYTE;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
    function automatic int bidx_w(input int nbits, input int nbyte);
        return (nbits / nbyte > 1) ? $clog2(nbits / nbyte) : 1;
    endfunction
endpackage

// File: rtl/debug_byte_sel.sv
// debug_byte_sel: combinational MSB-first byte selector, index 0 is the top byte of the word.
module debug_byte_sel #(
    parameter int NBITS = 32,
    parameter int BYTE  = 8,
    parameter int BW    = 2
) (
    input  logic [NBITS-1:0] word_i,
    input  logic [BW-1:0]    idx_i,
    output logic [BYTE-1:0]  byte_o
);
    always_comb begin
        byte_o = '0;
        for (int k = 0; k < NBITS / BYTE; k++)
            if (idx_i == BW'(k)) byte_o = word_i[NBITS-1-k*BYTE -: BYTE];
    end
endmodule

// File: rtl/debug_reg_dump.sv
// debug_reg_dump: sweeps the register file over its debug port and streams every word,
// MSB byte first, to the UART transmitter through a start/done handshake.
module debug_reg_dump
    import debug_pkg::*;
#(
    parameter int REGS   = 5,
    parameter int NBITS  = DEF_NBITS,
    parameter int CELDAS = 32,
    parameter int BYTE   = DEF_BYTE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_Start,
    output logic [REGS-1:0]  o_RegDebug,
    input  logic [NBITS-1:0] i_RegDebugDato,
    output logic [BYTE-1:0]  o_TxDato,
    output logic             o_TxStart,
    input  logic             i_TxDone,
    output logic             o_Busy,
    output logic             o_Done
);
    localparam int BPW = NBITS / BYTE;
    localparam int BW  = bidx_w(NBITS, BYTE);
    localparam logic [REGS-1:0] LAST_REG  = REGS'(CELDAS - 1);
    localparam logic [BW-1:0]   LAST_BYTE = BW'(BPW - 1);

    state_t            state_q, state_d;
    logic [REGS-1:0]   reg_q, reg_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [NBITS-1:0]  word_q, word_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            reg_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        byte_d  = byte_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (i_Start) begin
                reg_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                word_d  = i_RegDebugDato;
                byte_d  = '0;
                state_d = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: if (i_TxDone) begin
                if (byte_q != LAST_BYTE) begin
                    byte_d  = byte_q + BW'(1);
                    state_d = SEND;
                end else if (reg_q != LAST_REG) begin
                    reg_d   = reg_q + REGS'(1);
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word and byte index only move at LOAD/SEND entry, so the selected byte holds between starts.
    debug_byte_sel #(.NBITS(NBITS), .BYTE(BYTE), .BW(BW)) u_sel (
        .word_i(word_q),
        .idx_i (byte_q),
        .byte_o(o_TxDato)
    );

    assign o_RegDebug = reg_q;
    assign o_TxStart  = state_q == SEND;
    assign o_Busy     = state_q inside {LOAD, SEND, WAIT};
    assign o_Done     = state_q == DONE;
endmodule

// File: tb/tb_debug_reg_dump.sv
// tb_debug_reg_dump: scoreboard bench with a register-file model and a UART TX model.
module tb_debug_reg_dump;
    localparam int NREG = 32;
    localparam int NBPW = 4;
    localparam int NB   = NREG * NBPW;

    logic        clk = 0, reset = 1, i_Start = 0, i_TxDone = 0;
    logic [4:0]  o_RegDebug;
    logic [31:0] i_RegDebugDato;
    logic [7:0]  o_TxDato;
    logic        o_TxStart, o_Busy, o_Done;
    logic [31:0] mem [NREG];

    debug_reg_dump dut (
        .clk(clk), .reset(reset), .i_Start(i_Start), .o_RegDebug(o_RegDebug),
        .i_RegDebugDato(i_RegDebugDato), .o_TxDato(o_TxDato), .o_TxStart(o_TxStart),
        .i_TxDone(i_TxDone), .o_Busy(o_Busy), .o_Done(o_Done)
    );

    assign i_RegDebugDato = mem[o_RegDebug];
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 same word (done+1), 1 new register (done+2), 2 dump start (ref+2), 3 held-start redump (o_Done+3)
    typedef struct {
        bit         is_done;
        logic [7:0] b;
        logic [4:0] r;
        int         kind;
        int         ref_cyc;
    } exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0, n_tx = 0, n_done = 0;
    int last_done_cyc = -100, last_odone_cyc = -100;
    int dly = 10, cnt = 0;
    bit rnd_dly = 0;
    int inj_req = 0, inj_ack = 0, idle_req = 0, idle_ack = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_dump(input int kind, input int refc);
        exp_t e;
        for (int r = 0; r < NREG; r++)
            for (int k = 0; k < NBPW; k++) begin
                e.is_done = 0;
                e.b       = 8'((mem[r] >> (8 * (NBPW - 1 - k))) & 32'hFF);
                e.r       = 5'(r);
                e.kind    = (r == 0 && k == 0) ? kind : (k == 0 ? 1 : 0);
                e.ref_cyc = refc;
                q.push_back(e);
            end
        e.is_done = 1;
        e.b = 0; e.r = 0; e.kind = 0; e.ref_cyc = 0;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT starts a byte or signals completion.
    initial begin
        exp_t e;
        int want;
        forever begin
            @(negedge clk);
            if (!reset && o_TxStart) begin
                n_tx++;
                if (q.size() == 0 || q[0].is_done) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_txstart: got byte %0h expected none (cyc %0d)", o_TxDato, cyc);
                end else begin
                    e = q.pop_front();
                    want = e.kind == 0 ? last_done_cyc + 1 : e.kind == 1 ? last_done_cyc + 2 :
                           e.kind == 2 ? e.ref_cyc + 2 : last_odone_cyc + 3;
                    chk("tx_byte", o_TxDato, e.b);
                    chk("reg_addr", o_RegDebug, e.r);
                    chk("tx_timing", cyc, want);
                    chk("busy_in_send", o_Busy, 1);
                end
            end
            if (!reset && o_Done) begin
                n_done++;
                last_odone_cyc = cyc;
                if (q.size() == 0 || !q[0].is_done) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got o_Done with %0d bytes pending (cyc %0d)", q.size(), cyc);
                end else begin
                    void'(q.pop_front());
                    chk("done_timing", cyc, last_done_cyc + 1);
                    chk("busy_in_done", o_Busy, 0);
                end
            end
        end
    end

    // UART TX model: answers each o_TxStart with a one-cycle i_TxDone after a delay.
    initial begin
        forever begin
            @(negedge clk);
            i_TxDone = 0;
            if (reset) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        i_TxDone = 1;
                        last_done_cyc = cyc;
                    end
                end
                if (o_TxStart) begin
                    cnt = rnd_dly ? int'($urandom_range(1, 12)) : dly;
                    if (inj_req != inj_ack) begin
                        i_TxDone = 1;
                        inj_ack = inj_req;
                    end
                end
                if (idle_req != idle_ack) begin
                    i_TxDone = 1;
                    idle_ack = idle_req;
                end
            end
        end
    end

    int base, d0;

    task automatic start_dump();
        base = n_tx;
        d0 = n_done;
        push_dump(2, cyc);
        i_Start = 1;
        @(negedge clk);
        i_Start = 0;
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (k < 5000) begin
            @(negedge clk);
            #2;
            if (n_tx - base >= n) break;
            k++;
        end
        chk("wait_bytes_bound", k < 5000, 1);
    endtask

    task automatic wait_end(input string nm, input int ndump);
        int k = 0;
        while ((q.size() != 0 || o_Busy) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk({nm, "_bound"}, k < 8000, 1);
        chk({nm, "_bytes"}, n_tx - base, ndump * NB);
        chk({nm, "_dones"}, n_done - d0, ndump);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) mem[i] = i;
        repeat (3) @(negedge clk);
        chk("rst_regdebug", o_RegDebug, 0);
        chk("rst_txdato", o_TxDato, 0);
        chk("rst_txstart", o_TxStart, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_done", o_Done, 0);
        reset = 0;
        @(negedge clk);
        idle_req++;
        repeat (4) @(negedge clk);
        chk("idle_spurious_busy", o_Busy, 0);

        start_dump();
        wait_end("basic", 1);

        mem[5] = 32'hDEADBEEF;
        dly = 4;
        start_dump();
        wait_end("deadbeef", 1);

        start_dump();
        wait_bytes(40);
        i_Start = 1;
        @(negedge clk);
        i_Start = 0;
        wait_end("repulse", 1);

        start_dump();
        for (int j = 0; j < 6; j++) begin
            inj_req++;
            wait_bytes(10 * (j + 1));
        end
        wait_end("spurious_send", 1);

        start_dump();
        wait_bytes(38);
        reset = 1;
        #1;
        chk("async_rst_regdebug", o_RegDebug, 0);
        chk("async_rst_txdato", o_TxDato, 0);
        chk("async_rst_txstart", o_TxStart, 0);
        chk("async_rst_busy", o_Busy, 0);
        chk("async_rst_done", o_Done, 0);
        q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        start_dump();
        wait_end("restart", 1);

        for (int i = 0; i < NREG; i++) mem[i] = $urandom;
        rnd_dly = 1;
        start_dump();
        wait_end("random", 1);

        rnd_dly = 0;
        dly = 1;
        base = n_tx;
        d0 = n_done;
        push_dump(2, cyc);
        push_dump(3, 0);
        i_Start = 1;
        begin
            int k = 0;
            while (n_done - d0 < 1 && k < 5000) begin
                @(negedge clk);
                #2;
                k++;
            end
            chk("b2b_first_bound", k < 5000, 1);
        end
        repeat (2) @(negedge clk);
        i_Start = 0;
        wait_end("back2back", 2);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end
endmodule
